puf_challenge_driver: RTL and testbench
=======================================

PUF_CHALLENGE_DRIVER -- requirements
Module: puf_challenge_driver

Interface
- REQ-001 SHALL have parameter N, default 4: challenge width per operand; the response width is 2N.
- REQ-002 SHALL have parameter SETTLE, default 8: number of cycles the challenge is held before sampling (minimum 1).
- REQ-003 SHALL have parameter VOTES, default 5: number of response samples per measurement (odd, minimum 1).
- REQ-004 SHALL have parameter TAPS, default 8'hB8: Galois LFSR feedback mask, width 2N.
- REQ-005 SHALL have clk, input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-006 SHALL have rst, input, 1 bit: synchronous, active-high reset.
- REQ-007 SHALL have req, input, 1 bit: measurement request.
- REQ-008 SHALL have req_ready, output, 1 bit: high only in IDLE.
- REQ-009 SHALL have seed_load, input, 1 bit, and seed, input, 2N bits: LFSR seed load.
- REQ-010 SHALL have tune_in, input, 5 bits: delay tune setting.
- REQ-011 SHALL have tune_level, output, 5 bits: registered tune_in, captured at request accept.
- REQ-012 SHALL have challenge1 and challenge2, outputs, N bits each: lfsr[2N-1:N] and lfsr[N-1:0] respectively, as captured at accept.
- REQ-013 SHALL have start, output, 1 bit: PUF evaluate enable.
- REQ-014 SHALL have response, input, 2N bits: arbiter outputs from the PUF.
- REQ-015 SHALL have resp_valid, output, 1 bit; resp_ready, input, 1 bit.
- REQ-016 SHALL have resp_data, output, 2N bits; chal_data, output, 2N bits (the challenge used); unstable_mask, output, 2N bits.

Function
- REQ-017 SHALL implement the FSM states IDLE, APPLY, SETTLE, SAMPLE and DONE.
- REQ-018 IDLE: on req && req_ready SHALL capture the LFSR value into the challenge register, capture tune_in, advance the LFSR one step, and go to APPLY.
- REQ-019 APPLY SHALL last 1 cycle, assert start, and clear the per-bit vote counters.
- REQ-020 start SHALL stay high from APPLY through the last SAMPLE cycle and be low otherwise.
- REQ-021 SETTLE SHALL last exactly SETTLE cycles, counted by a down-counter.
- REQ-022 SAMPLE SHALL last VOTES cycles; each cycle, vote counter i SHALL increment when response[i]=1.
- REQ-023 On leaving SAMPLE: resp_data[i] SHALL be 1 if and only if count[i] > VOTES/2 (integer division).
- REQ-024 On leaving SAMPLE: unstable_mask[i] SHALL be 1 if and only if count[i] is neither 0 nor VOTES.
- REQ-025 On leaving SAMPLE: chal_data SHALL be {challenge1, challenge2}.
- REQ-026 DONE SHALL hold resp_valid=1 with resp_data, chal_data and unstable_mask stable until resp_ready=1.
- REQ-027 DONE with resp_ready=1 SHALL go to IDLE on the next cycle; resp_valid drops that cycle.
- REQ-028 Latency SHALL be 1+SETTLE+VOTES cycles from the accept edge to the first resp_valid cycle: 14 cycles at defaults.
- REQ-029 LFSR update SHALL be: if lfsr[0] then lfsr = (lfsr>>1) ^ TAPS, else lfsr = lfsr>>1.
- REQ-030 seed_load SHALL take effect only in IDLE and SHALL be ignored in all other states.
- REQ-031 If seed_load and req occur in the same IDLE cycle, the seed SHALL win and the req SHALL NOT be accepted.
- REQ-032 A seed of all-zeros SHALL load all-ones instead, to avoid LFSR lockup.
- REQ-033 req outside IDLE SHALL be ignored and SHALL NOT be queued.
- REQ-034 Vote counters SHALL be ceil(log2(VOTES+1)) bits wide and SHALL never wrap.

Reset
- REQ-035 rst SHALL force state=IDLE and lfsr=all-ones.
- REQ-036 rst SHALL force all counters, challenge1, challenge2, tune_level, start, resp_valid, resp_data, chal_data and unstable_mask to 0; req_ready SHALL be 1 on the first cycle after reset.
- REQ-037 rst asserted in any state SHALL abort the measurement, and start SHALL be low on the cycle after the reset edge.

Configuration
- REQ-038 Macro PUF_MAJORITY_VOTE_EN defined: behaviour SHALL be exactly as REQ-022 to REQ-024.
- REQ-039 Macro PUF_MAJORITY_VOTE_EN undefined: VOTES SHALL be ignored and SAMPLE SHALL last 1 cycle.
- REQ-040 Macro PUF_MAJORITY_VOTE_EN undefined: resp_data SHALL equal response sampled in that cycle, unstable_mask SHALL be constant 0, and latency SHALL be SETTLE+2 cycles.

Verification
- REQ-041 Reset, then req=1 with response held at 8'hA5 -> 14 cycles later resp_valid=1, resp_data=8'hA5, unstable_mask=0, chal_data=8'hFF.
- REQ-042 Seed 8'h01, then two requests -> first chal_data=8'h01, second chal_data=8'hB8.
- REQ-043 response bit0 high for 3 of 5 SAMPLE cycles, others 0 -> resp_data=8'h01, unstable_mask=8'h01.
- REQ-044 resp_ready held 0 for 10 cycles in DONE -> resp_valid and data stable for all 10 cycles; req pulses during that window are ignored.
- REQ-045 rst pulse during SETTLE -> start=0 and req_ready=1 next cycle, resp_valid never asserts; seed load of 8'h00 -> next chal_data=8'hFF.
- REQ-046 Macro PUF_MAJORITY_VOTE_EN undefined, response=8'h3C -> resp_valid at cycle 10, resp_data=8'h3C.

Source files
------------

// File: rtl/puf_challenge_driver.sv
// puf_challenge_driver: drives LFSR-generated challenges into an arbiter PUF,
// waits for the delay lines to settle, samples the response and hands it off
// over a valid/ready interface.
//
// Optional feature macro: PUF_MAJORITY_VOTE_EN
//   defined   -> SAMPLE lasts VOTES cycles; per-bit majority vote and
//                instability mask are reported.
//   undefined -> SAMPLE lasts one cycle; response is reported as sampled and
//                unstable_mask is always 0 (VOTES only sizes the sample counter).
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req / req_ready          measurement request (ready only in IDLE)
//   seed_load, seed          LFSR seed load (IDLE only, wins over req)
//   tune_in / tune_level     delay tune, captured at request accept
//   challenge1, challenge2   upper / lower halves of the captured challenge
//   start                    PUF evaluate enable (APPLY through last SAMPLE)
//   response                 arbiter outputs from the PUF
//   resp_valid / resp_ready  result handshake
//   resp_data, chal_data     measured response and the challenge used
//   unstable_mask            bits that did not vote unanimously
module puf_challenge_driver #(
    parameter int unsigned      N      = 4,
    parameter int unsigned      SETTLE = 8,
    parameter int unsigned      VOTES  = 5,
    parameter logic [2*N-1:0]   TAPS   = 8'hB8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              req_ready,
    input  logic              seed_load,
    input  logic [2*N-1:0]    seed,
    input  logic [4:0]        tune_in,
    output logic [4:0]        tune_level,
    output logic [N-1:0]      challenge1,
    output logic [N-1:0]      challenge2,
    output logic              start,
    input  logic [2*N-1:0]    response,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [2*N-1:0]    resp_data,
    output logic [2*N-1:0]    chal_data,
    output logic [2*N-1:0]    unstable_mask
);

    localparam int unsigned W  = 2 * N;
    localparam int unsigned SW = $clog2(SETTLE + 1);
    localparam int unsigned CW = $clog2(VOTES + 1);
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int unsigned SAMPLES = VOTES;
`else
    localparam int unsigned SAMPLES = 1;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    lfsr_q, lfsr_d;
    logic [W-1:0]    chal_q, chal_d;
    logic [4:0]      tune_q, tune_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [CW-1:0]   samp_q, samp_d;
    logic            start_q, start_d;
    logic            req_ready_q, req_ready_d;
    logic            valid_q, valid_d;
    logic [W-1:0]    resp_q, resp_d;
    logic [W-1:0]    chal_out_q, chal_out_d;
    logic [W-1:0]    unst_q, unst_d;
`ifdef PUF_MAJORITY_VOTE_EN
    logic [CW-1:0]   cnt_q  [W];
    logic [CW-1:0]   cnt_d  [W];
    logic [CW-1:0]   cnt_nx [W];
`endif

    // One Galois LFSR step.
    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] v);
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

`ifdef PUF_MAJORITY_VOTE_EN
    // Vote counters including the current SAMPLE cycle; saturate, never wrap.
    always_comb begin
        for (int i = 0; i < W; i++) begin
            cnt_nx[i] = cnt_q[i];
            if (response[i] && (cnt_q[i] != CW'(VOTES))) begin
                cnt_nx[i] = cnt_q[i] + CW'(1);
            end
        end
    end
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        chal_d      = chal_q;
        tune_d      = tune_q;
        settle_d    = settle_q;
        samp_d      = samp_q;
        start_d     = start_q;
        req_ready_d = req_ready_q;
        valid_d     = valid_q;
        resp_d      = resp_q;
        chal_out_d  = chal_out_q;
        unst_d      = unst_q;
`ifdef PUF_MAJORITY_VOTE_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Seed load has priority; an all-zero seed would lock the LFSR.
                if (seed_load) begin
                    lfsr_d = (seed == '0) ? '1 : seed;
                end else if (req && req_ready_q) begin
                    chal_d      = lfsr_q;
                    tune_d      = tune_in;
                    lfsr_d      = lfsr_step(lfsr_q);
                    start_d     = 1'b1;
                    req_ready_d = 1'b0;
                    state_d     = ST_APPLY;
                end
            end
            ST_APPLY: begin
`ifdef PUF_MAJORITY_VOTE_EN
                for (int i = 0; i < W; i++) begin
                    cnt_d[i] = '0;
                end
`endif
                settle_d = SW'(SETTLE - 1);
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    samp_d  = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            ST_SAMPLE: begin
`ifdef PUF_MAJORITY_VOTE_EN
                cnt_d = cnt_nx;
`endif
                if (samp_q == CW'(SAMPLES - 1)) begin
`ifdef PUF_MAJORITY_VOTE_EN
                    for (int i = 0; i < W; i++) begin
                        resp_d[i] = (cnt_nx[i] > CW'(VOTES / 2));
                        unst_d[i] = (cnt_nx[i] != '0) && (cnt_nx[i] != CW'(VOTES));
                    end
`else
                    resp_d = response;
                    unst_d = '0;
`endif
                    chal_out_d = chal_q;
                    start_d    = 1'b0;
                    valid_d    = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    samp_d = samp_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    valid_d     = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                start_d     = 1'b0;
                valid_d     = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= '1;
            chal_q      <= '0;
            tune_q      <= '0;
            settle_q    <= '0;
            samp_q      <= '0;
            start_q     <= 1'b0;
            req_ready_q <= 1'b1;
            valid_q     <= 1'b0;
            resp_q      <= '0;
            chal_out_q  <= '0;
            unst_q      <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= '0;
            end
`endif
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            chal_q      <= chal_d;
            tune_q      <= tune_d;
            settle_q    <= settle_d;
            samp_q      <= samp_d;
            start_q     <= start_d;
            req_ready_q <= req_ready_d;
            valid_q     <= valid_d;
            resp_q      <= resp_d;
            chal_out_q  <= chal_out_d;
            unst_q      <= unst_d;
`ifdef PUF_MAJORITY_VOTE_EN
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
`endif
        end
    end

    assign req_ready     = req_ready_q;
    assign tune_level    = tune_q;
    assign challenge1    = chal_q[W-1:N];
    assign challenge2    = chal_q[N-1:0];
    assign start         = start_q;
    assign resp_valid    = valid_q;
    assign resp_data     = resp_q;
    assign chal_data     = chal_out_q;
    assign unstable_mask = unst_q;

endmodule

// File: tb/tb_puf_challenge_driver.sv
// Testbench for puf_challenge_driver: directed vector table, hand-written
// corner-case sequences and randomized measurements checked against a
// behavioural model (LFSR value list, per-bit vote counts by arithmetic).
module tb_puf_challenge_driver;

    localparam int unsigned W      = 8;
    localparam int unsigned SETTLE = 8;
    localparam int unsigned VOTES  = 5;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int unsigned SAMPLES = VOTES;
`else
    localparam int unsigned SAMPLES = 1;
`endif
    // Edges from the accept edge to the first resp_valid cycle.
    localparam int unsigned LAT = 1 + SETTLE + SAMPLES;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0;
    logic         req_ready;
    logic         seed_load = 1'b0;
    logic [W-1:0] seed = '0;
    logic [4:0]   tune_in = '0;
    logic [4:0]   tune_level;
    logic [3:0]   challenge1, challenge2;
    logic         start;
    logic [W-1:0] response = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [W-1:0] resp_data, chal_data, unstable_mask;

    puf_challenge_driver #(.N(4), .SETTLE(SETTLE), .VOTES(VOTES), .TAPS(8'hB8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_ready(req_ready),
        .seed_load(seed_load), .seed(seed), .tune_in(tune_in), .tune_level(tune_level),
        .challenge1(challenge1), .challenge2(challenge2), .start(start),
        .response(response), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .chal_data(chal_data), .unstable_mask(unstable_mask)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] m_lfsr;            // model LFSR value
    logic [W-1:0] pat [SAMPLES];     // response per sample cycle

    typedef struct {
        bit         do_seed;
        logic [7:0] seed;
        logic [7:0] resp;
        logic [7:0] exp_chal;
        int         hold;
    } vec_t;

    vec_t tbl [7];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] m_step(input logic [7:0] v);
        logic [7:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 8'hB8;
        return r;
    endfunction

    task automatic load_seed(input logic [7:0] s);
        seed_load = 1'b1;
        seed      = s;
        tick();
        seed_load = 1'b0;
        m_lfsr    = (s == 8'h00) ? 8'hFF : s;
    endtask

    // One full measurement from IDLE back to IDLE, checked cycle by cycle.
    task automatic measure(input int hold, input bit pulse_req, input bit try_seed);
        logic [7:0] exp_chal, exp_resp, exp_unst;
        logic [4:0] tune;
        int         cnt;
        bit         in_sample;
        chk1("req_ready_idle", req_ready, 1'b1);
        tune     = 5'($urandom);
        tune_in  = tune;
        req      = 1'b1;
        exp_chal = m_lfsr;
        m_lfsr   = m_step(m_lfsr);
        for (int b = 0; b < W; b++) begin
            cnt = 0;
            for (int s = 0; s < SAMPLES; s++) cnt += int'(pat[s][b]);
            exp_resp[b] = (cnt > SAMPLES / 2);
            exp_unst[b] = (cnt != 0) && (cnt != SAMPLES);
        end
        tick();
        req     = 1'b0;
        tune_in = ~tune;
        for (int e = 1; e <= LAT; e++) begin
            chk1("start_busy", start, 1'b1);
            chk1("valid_busy", resp_valid, 1'b0);
            chk1("ready_busy", req_ready, 1'b0);
            in_sample = (e >= SETTLE + 2) && (e <= SETTLE + 1 + SAMPLES);
            response  = in_sample ? pat[e - SETTLE - 2] : 8'($urandom);
            seed_load = try_seed && (e == 3);
            seed      = 8'h55;
            req       = pulse_req ? 1'($urandom) : 1'b0;
            tick();
        end
        seed_load = 1'b0;
        chk1("valid_done", resp_valid, 1'b1);
        chk1("start_done", start, 1'b0);
        chk8("resp_data", resp_data, exp_resp);
        chk8("chal_data", chal_data, exp_chal);
        chk8("unstable", unstable_mask, exp_unst);
        chk8("tune_level", 8'(tune_level), 8'(tune));
        chk8("challenge1", 8'(challenge1), 8'(exp_chal[7:4]));
        chk8("challenge2", 8'(challenge2), 8'(exp_chal[3:0]));
        for (int h = 0; h < hold; h++) begin
            resp_ready = 1'b0;
            req        = 1'($urandom);
            response   = 8'($urandom);
            tick();
            chk1("valid_hold", resp_valid, 1'b1);
            chk1("ready_hold", req_ready, 1'b0);
            chk1("start_hold", start, 1'b0);
            chk8("resp_hold", resp_data, exp_resp);
            chk8("chal_hold", chal_data, exp_chal);
            chk8("unst_hold", unstable_mask, exp_unst);
        end
        req        = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk1("valid_drop", resp_valid, 1'b0);
        chk1("ready_back", req_ready, 1'b1);
        tick();
        chk1("no_queued_req", start, 1'b0);
    endtask

    initial begin
        bit         seen_valid;
        logic [7:0] exp_u;

        tbl[0] = '{1'b0, 8'h00, 8'hA5, 8'hFF, 10};
        tbl[1] = '{1'b1, 8'h01, 8'h00, 8'h01, 0};
        tbl[2] = '{1'b0, 8'h00, 8'h3C, 8'hB8, 2};
        tbl[3] = '{1'b1, 8'h00, 8'hFF, 8'hFF, 1};
        tbl[4] = '{1'b0, 8'h00, 8'h5A, 8'hC7, 3};
        tbl[5] = '{1'b1, 8'h80, 8'h81, 8'h80, 0};
        tbl[6] = '{1'b0, 8'h00, 8'h0F, 8'h40, 4};

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        chk1("rst_ready", req_ready, 1'b1);
        chk1("rst_start", start, 1'b0);
        chk1("rst_valid", resp_valid, 1'b0);
        chk8("rst_resp", resp_data, 8'h00);
        chk8("rst_chal", chal_data, 8'h00);
        chk8("rst_unst", unstable_mask, 8'h00);
        chk8("rst_tune", 8'(tune_level), 8'h00);
        chk8("rst_c1", 8'(challenge1), 8'h00);
        chk8("rst_c2", 8'(challenge2), 8'h00);
        rst    = 1'b0;
        m_lfsr = 8'hFF;

        // Directed vector table: constant response, known challenge sequence.
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].do_seed) load_seed(tbl[i].seed);
            for (int s = 0; s < SAMPLES; s++) pat[s] = tbl[i].resp;
            measure(tbl[i].hold, 1'b1, 1'b0);
            chk8("tbl_chal", chal_data, tbl[i].exp_chal);
            chk8("tbl_resp", resp_data, tbl[i].resp);
            chk8("tbl_unst", unstable_mask, 8'h00);
        end

        // Bit 0 high in 3 of the sample cycles.
        for (int s = 0; s < SAMPLES; s++) pat[s] = 8'h00;
        pat[0] = 8'h01;
`ifdef PUF_MAJORITY_VOTE_EN
        pat[2] = 8'h01;
        pat[3] = 8'h01;
        exp_u  = 8'h01;
`else
        exp_u  = 8'h00;
`endif
        measure(0, 1'b0, 1'b0);
        chk8("vote_resp", resp_data, 8'h01);
        chk8("vote_unst", unstable_mask, exp_u);

        // Seed and request in the same IDLE cycle: seed wins.
        seed_load = 1'b1;
        seed      = 8'h3A;
        req       = 1'b1;
        tick();
        seed_load = 1'b0;
        req       = 1'b0;
        m_lfsr    = 8'h3A;
        chk1("seed_wins_start", start, 1'b0);
        chk1("seed_wins_ready", req_ready, 1'b1);
        tick();
        chk1("seed_wins_noq", start, 1'b0);
        for (int s = 0; s < SAMPLES; s++) pat[s] = 8'($urandom);
        measure(1, 1'b0, 1'b1);
        chk8("seed_chal", chal_data, 8'h3A);

        // Reset during SETTLE aborts the measurement.
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (4) tick();
        chk1("pre_abort_start", start, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_lfsr = 8'hFF;
        chk1("abort_start", start, 1'b0);
        chk1("abort_ready", req_ready, 1'b1);
        chk1("abort_valid", resp_valid, 1'b0);
        chk8("abort_c1", 8'(challenge1), 8'h00);
        seen_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (resp_valid) seen_valid = 1'b1;
        end
        chk1("abort_never_valid", seen_valid, 1'b0);
        load_seed(8'h00);
        for (int s = 0; s < SAMPLES; s++) pat[s] = 8'($urandom);
        measure(0, 1'b0, 1'b0);
        chk8("zero_seed_chal", chal_data, 8'hFF);

        // Randomized measurements against the model.
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(3, 0) == 0) load_seed(($urandom_range(4, 0) == 0) ? 8'h00 : 8'($urandom));
            for (int s = 0; s < SAMPLES; s++) pat[s] = 8'($urandom);
            measure(int'($urandom_range(12, 0)), 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
